// File: rtl/lfo_pkg.sv
// Shared types and constants for the LFO arbiter.
//   lfo_state_t  : arbiter FSM states
//   FREQ_*       : generator frequency codes (2'b00 is passed through as-is)
//   FREQ_RST     : frequency code held after reset
//   ptr_width()  : round-robin pointer width, never below one bit
package lfo_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        RUN    = 3'd2,
        STOP   = 3'd3,
        SETTLE = 3'd4
    } lfo_state_t;

    localparam logic [1:0] FREQ_SLOW = 2'b01;
    localparam logic [1:0] FREQ_MID  = 2'b10;
    localparam logic [1:0] FREQ_FAST = 2'b11;
    localparam logic [1:0] FREQ_RST  = FREQ_SLOW;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lfo_rr_pick.sv
// Round-robin find-first-set: returns the first set request at or above
// i_ptr, wrapping modulo N_REQ.
//   i_req  : request vector
//   i_ptr  : search start index
//   o_idx  : selected index (0 when none set)
//   o_vld  : at least one request set
module lfo_rr_pick
    import lfo_pkg::*;
#(
    parameter int N_REQ = 2,
    localparam int PW   = ptr_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [PW-1:0]    o_idx,
    output logic             o_vld
);

    int j;

    always_comb begin
        o_idx = '0;
        o_vld = 1'b0;
        j     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(i_ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!o_vld && i_req[j]) begin
                o_vld = 1'b1;
                o_idx = j[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/lfo_arbiter.sv
// Shares one triangle LFO generator among N_REQ effect requesters with
// round-robin arbitration and a minimum time slice. Every start is
// followed by a stop, and every stop by a settle cycle before any restart.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_req             : level request per requester
//   i_freq            : 2-bit frequency code per requester, [2k+1:2k]
//   o_gnt             : one-hot grant (START/RUN), else zero
//   o_busy            : high outside IDLE
//   o_tri_start       : one-cycle generator start pulse
//   o_tri_stop        : one-cycle generator stop pulse
//   o_tri_freq        : frequency code for the generator
//
// state  | meaning
// IDLE   | waiting for any request, pick next owner from pointer
// START  | start pulse, grant owner, clear slice counter
// RUN    | owner holds generator; watch release / freq change / slice
// STOP   | stop pulse, grant withdrawn
// SETTLE | guaranteed quiet cycle for the generator
module lfo_arbiter
    import lfo_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int SLICE_CYCLES = 48000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [2*N_REQ-1:0] i_freq,
    output logic [N_REQ-1:0]   o_gnt,
    output logic               o_busy,
    output logic               o_tri_start,
    output logic               o_tri_stop,
    output logic [1:0]         o_tri_freq
);

    localparam int PW = ptr_width(N_REQ);
    localparam int CW = (SLICE_CYCLES > 0) ? $clog2(SLICE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] SLICE_MAX = CW'(SLICE_CYCLES);
    localparam logic [PW-1:0] PTR_LAST  = PW'(N_REQ - 1);

    lfo_state_t     state, state_nx;
    logic [PW-1:0]  ptr, ptr_nx;
    logic [PW-1:0]  owner, owner_nx;
    logic [1:0]     freq_lat, freq_nx;
    logic [CW-1:0]  cnt, cnt_nx;

    logic [N_REQ-1:0] gnt_nx;
    logic             busy_nx, start_nx, stop_nx;

    logic [PW-1:0]    pick_idx;
    logic             pick_vld;
    logic [1:0]       pick_freq, owner_freq;
    logic [PW-1:0]    owner_inc;
    logic [CW-1:0]    cnt_inc;
    logic [N_REQ-1:0] owner_mask;
    logic             other_req;

    lfo_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req (i_req),
        .i_ptr (ptr),
        .o_idx (pick_idx),
        .o_vld (pick_vld)
    );

    assign pick_freq  = i_freq[2*int'(pick_idx) +: 2];
    assign owner_freq = i_freq[2*int'(owner) +: 2];
    assign owner_inc  = (owner == PTR_LAST) ? '0 : owner + 1'b1;
    // Counter value including the current RUN cycle, so a slice of N
    // cycles means exactly N RUN cycles before the handoff.
    assign cnt_inc    = (cnt == SLICE_MAX) ? cnt : cnt + 1'b1;
    assign other_req  = |(i_req & ~owner_mask);
    assign o_tri_freq = freq_lat;

    always_comb begin
        owner_mask        = '0;
        owner_mask[owner] = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            freq_lat    <= FREQ_RST;
            cnt         <= '0;
            o_gnt       <= '0;
            o_busy      <= 1'b0;
            o_tri_start <= 1'b0;
            o_tri_stop  <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            owner       <= owner_nx;
            freq_lat    <= freq_nx;
            cnt         <= cnt_nx;
            o_gnt       <= gnt_nx;
            o_busy      <= busy_nx;
            o_tri_start <= start_nx;
            o_tri_stop  <= stop_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        owner_nx = owner;
        freq_nx  = freq_lat;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    owner_nx = pick_idx;
                    freq_nx  = pick_freq;
                    cnt_nx   = '0;
                    state_nx = START;
                end
            end
            START: begin
                cnt_nx   = '0;
                state_nx = RUN;
            end
            RUN: begin
                cnt_nx = cnt_inc;
                if (!i_req[owner]) begin
                    ptr_nx   = owner_inc;
                    state_nx = STOP;
                end else if (owner_freq != freq_lat) begin
                    // Same owner restarts at the new rate.
                    ptr_nx   = owner;
                    state_nx = STOP;
                end else if ((cnt_inc == SLICE_MAX) && other_req) begin
                    ptr_nx   = owner_inc;
                    state_nx = STOP;
                end
            end
            STOP:    state_nx = SETTLE;
            SETTLE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        gnt_nx   = '0;
        busy_nx  = (state_nx != IDLE);
        start_nx = (state_nx == START);
        stop_nx  = (state_nx == STOP);
        if ((state_nx == START) || (state_nx == RUN)) begin
            gnt_nx[owner_nx] = 1'b1;
        end
    end

endmodule

// File: tb/tb_lfo_arbiter.sv
module tb_lfo_arbiter;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [1:0] i_req = 2'b00;
    logic [3:0] i_freq = 4'b0000;
    logic [1:0] o_gnt;
    logic       o_busy;
    logic       o_tri_start;
    logic       o_tri_stop;
    logic [1:0] o_tri_freq;

    int n_tot = 0;
    int n_bad = 0;

    lfo_arbiter #(.N_REQ(2), .SLICE_CYCLES(8)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_freq      (i_freq),
        .o_gnt       (o_gnt),
        .o_busy      (o_busy),
        .o_tri_start (o_tri_start),
        .o_tri_stop  (o_tri_stop),
        .o_tri_freq  (o_tri_freq)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // {gnt[1:0], busy, start, stop}
    function automatic logic [4:0] outs();
        return {o_gnt, o_busy, o_tri_start, o_tri_stop};
    endfunction

    initial begin
        logic [1:0] exp_g;
        logic [1:0] exp_f;
        int n;
        int guard;

        repeat (3) tick();
        check("rst_outs", outs(), 5'b00_000);
        check("rst_freq", o_tri_freq, 2'b01);
        i_rst = 1'b0;
        tick();
        check("idle_after_rst", outs(), 5'b00_000);

        // request -> start next cycle
        i_freq = 4'b0010;
        i_req  = 2'b01;
        tick();
        check("t1_start", outs(), 5'b01_110);
        check("t1_freq", o_tri_freq, 2'b10);
        tick();
        check("t1_run", outs(), 5'b01_100);
        tick();
        tick();
        check("t1_run_hold", outs(), 5'b01_100);

        // release
        i_req = 2'b00;
        tick();
        check("t2_stop", outs(), 5'b00_101);
        tick();
        check("t2_settle", outs(), 5'b00_100);
        tick();
        check("t2_idle", outs(), 5'b00_000);

        // frequency change restarts the same owner
        i_req = 2'b01;
        tick();
        check("t3_start", outs(), 5'b01_110);
        tick();
        tick();
        check("t3_run", outs(), 5'b01_100);
        i_freq = 4'b0011;
        tick();
        check("t3_stop", outs(), 5'b00_101);
        tick();
        check("t3_settle", outs(), 5'b00_100);
        tick();
        check("t3_idle", outs(), 5'b00_000);
        tick();
        check("t3_restart", outs(), 5'b01_110);
        check("t3_freq", o_tri_freq, 2'b11);
        tick();
        check("t3_run2", outs(), 5'b01_100);

        // asynchronous reset mid-RUN
        #2;
        i_rst = 1'b1;
        #1;
        check("rst_async", outs(), 5'b00_000);
        check("rst_async_freq", o_tri_freq, 2'b01);
        i_req = 2'b00;
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("post_rst_idle", outs(), 5'b00_000);
        end

        // slice rotation with both requesting
        i_freq = 4'b1110;
        i_req  = 2'b11;
        tick();
        for (int h = 0; h < 4; h++) begin
            exp_g = (h % 2 == 0) ? 2'b01 : 2'b10;
            exp_f = (h % 2 == 0) ? 2'b10 : 2'b11;
            check("rot_start", outs(), {exp_g, 3'b110});
            check("rot_freq", o_tri_freq, exp_f);
            n = 1;
            guard = 0;
            tick();
            while ((o_gnt == exp_g) && (guard < 40)) begin
                n++;
                guard++;
                tick();
            end
            check("rot_len", n, 9);
            check("rot_stop", outs(), 5'b00_101);
            tick();
            tick();
            tick();
        end

        // reset with both requesting: 0 first, then release moves pointer
        i_rst = 1'b1;
        i_req = 2'b00;
        tick();
        i_rst = 1'b0;
        tick();
        i_freq = 4'b1110;
        i_req  = 2'b11;
        tick();
        check("t5_first", outs(), 5'b01_110);
        tick();
        check("t5_run", outs(), 5'b01_100);
        // drop and freq change together: release must win
        i_req  = 2'b10;
        i_freq = 4'b1111;
        tick();
        check("t5_stop", outs(), 5'b00_101);
        i_req = 2'b11;
        tick();
        check("t5_settle", outs(), 5'b00_100);
        tick();
        check("t5_idle", outs(), 5'b00_000);
        tick();
        check("t5_ptr_win", outs(), 5'b10_110);
        check("t5_freq", o_tri_freq, 2'b11);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lfo_arbiter.md
# lfo_arbiter

Controller that shares one triangle LFO generator among `N_REQ` effect requesters (tremolo, vibrato, …). It arbitrates round-robin with a time slice, and sequences the generator's start/stop/frequency inputs. It guarantees every restart is preceded by a stop plus a settle cycle. The block sits between the effect-control logic and the triangle generator; the granted effect consumes the generator's sample output.

## Interface
- `N_REQ`, default 2: number of requesters, ≥1.
- `SLICE_CYCLES`, default 48000: minimum RUN cycles before a waiting requester may preempt the owner.

Ports (direction, width, meaning):
- `i_clk` in 1: clock.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_req` in `N_REQ`: level request per requester.
- `i_freq` in `2*N_REQ`: per-requester frequency code; requester k uses bits [2k+1:2k].
- `o_gnt` out `N_REQ`: one-hot grant, or zero.
- `o_busy` out 1: high in every state except IDLE.
- `o_tri_start` out 1: one-cycle start pulse to the generator.
- `o_tri_stop` out 1: one-cycle stop pulse to the generator.
- `o_tri_freq` out 2: frequency code to the generator, valid while `o_tri_start` is high.

## Operation
- All outputs are registered.
- Reset values:
  - `o_gnt=0`, `o_busy=0`, `o_tri_start=0`, `o_tri_stop=0`, `o_tri_freq=2'b01`.
  - State IDLE; round-robin pointer 0; slice counter 0; owner 0; latched frequency `2'b01`.
- IDLE:
  - If any `i_req` bit is set, select the first set index searching upward from the pointer, wrapping modulo `N_REQ`.
  - Latch that index as owner and latch its `i_freq` field.
  - Go to START.
- START (one cycle): `o_tri_start=1`, `o_tri_freq` = latched frequency, `o_gnt[owner]=1`, slice counter cleared. Go to RUN.
- RUN:
  - `o_gnt[owner]=1`.
  - Slice counter increments each cycle and saturates at `SLICE_CYCLES`.
  - Exit conditions, evaluated in priority order; the first true one applies:
    1. `i_req[owner]` low: release. Pointer becomes owner+1 (mod `N_REQ`). Go to STOP.
    2. Owner's `i_freq` differs from the latched frequency: restart. Pointer becomes owner. Go to STOP.
    3. Counter equals `SLICE_CYCLES` and any other `i_req` bit is set: rotate. Pointer becomes owner+1. Go to STOP.
- STOP (one cycle): `o_tri_stop=1`, `o_gnt=0`. Go to SETTLE.
- SETTLE (one cycle): all pulses 0, `o_gnt=0`. This gives the generator a guaranteed IDLE cycle. Go to IDLE.
- Frequency code 2'b00 is passed through unchanged; the generator maps it to the slow rate.
- With `N_REQ=1`, rotation never triggers.
- Arithmetic:
  - Slice counter width is `$clog2(SLICE_CYCLES+1)`; it saturates and never wraps.
  - Pointer width is `$clog2(N_REQ)`, minimum 1; the increment wraps at `N_REQ-1`.

## Timing
- Request to start pulse:
  - Request sampled in IDLE at cycle t.
  - `o_tri_start` and `o_gnt` are high at t+1.
  - RUN from t+2.
- Stop to next start:
  - STOP at s, SETTLE at s+1, IDLE at s+2.
  - START at s+3 at the earliest.
  - `o_gnt` is low from s through s+2.
- Request dropped during START: detected in the first RUN cycle, and STOP follows the next cycle. The generator always receives a stop after every start.
- Owner's request drop and frequency change in the same cycle: release wins.
- Requests arriving during STOP or SETTLE are served in the next IDLE cycle. No request is lost, because requests are levels.
- `o_tri_start` and `o_tri_stop` are never high in the same cycle; at most one pulse per state visit.
- Reset mid-operation:
  - Outputs clear asynchronously with no stop pulse issued.
  - The system reset must also reset the generator; its reset is active-low, so the top level inverts `i_rst`.

## Structure
- Package `lfo_pkg` holds:
  - The state enum: IDLE, START, RUN, STOP, SETTLE.
  - Frequency code constants: `FREQ_SLOW=2'b01`, `FREQ_MID=2'b10`, `FREQ_FAST=2'b11`.
  - The reset frequency constant.
- One sub-module, `lfo_rr_pick`: combinational find-first-set starting at the pointer with wrap-around.
  - Parameter `N_REQ`.
  - Inputs: request vector, pointer.
  - Outputs: index and valid.

## Test plan
- Reset, then `i_req=2'b01` with freq0=`2'b10` at cycle t → `o_tri_start=1`, `o_tri_freq=2'b10`, `o_gnt=2'b01` at t+1; `o_busy=1` from t+1.
- Owner drops its request at cycle r → `o_tri_stop=1` at r+1, `o_gnt=0` from r+1, `o_busy=0` at r+3.
- Owner 0 running, freq0 changed to `2'b11` at cycle f → stop at f+1, start with `o_tri_freq=2'b11` at f+4, `o_gnt` stays with owner 0.
- `SLICE_CYCLES=8`, both requesting from reset → grant 0 for exactly 8 RUN cycles, then stop, then grant 1; grants alternate indefinitely.
- `i_req=2'b11` at reset release with pointer 0 → requester 0 first; after release the pointer is 1, so requester 1 wins even if requester 0 re-requests.
- Assert `i_rst` mid-RUN → all outputs 0 immediately; after release with no requests, the block stays IDLE with no pulses.
